alarm_time: RTL and testbench

Holds the user-set alarm time of the alarm clock as a minutes/hours pair in 24-hour form. It advances minutes or hours by one per button press and presents the value as four BCD digits in 12-hour format with an AM/PM flag. It sits between the debounced set buttons and the display mux/alarm comparator, and runs in the 5 MHz system clock domain.

---
 rtl/alarm_time.sv | 129 ++++++++++++
 tb/tb_alarm_time.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/alarm_time.sv
// alarm_time: user-set alarm time of the alarm clock.
// Keeps minutes (0-59) and hours (0-23, 24-hour form) as binary counters.
// Each rising edge of a debounced set button advances its counter by one,
// and the value is shown as four BCD digits in 12-hour form with a PM flag.
// The outputs decode the counter registers directly, with no pipeline stage.
module alarm_time #(
  parameter int START_MINUTES = 0,
  parameter int START_HOURS   = 0
) (
  input  logic        i_Clk_5MHz,
  input  logic        i_Reset,
  input  logic        i_Minutes_Inc,
  input  logic        i_Hours_Inc,
  output logic [15:0] o_Alarm_Time,
  output logic        o_PM
);

  // Counter state
  logic [5:0] minutes;
  logic [4:0] hours;

  // Previous samples of the set buttons, used for rising-edge detection
  logic       minutes_inc_prev;
  logic       hours_inc_prev;

  // Single-cycle step requests
  logic       minutes_step;
  logic       hours_step;

  // Display decode intermediates
  logic [3:0] hours_12;
  logic [3:0] hours_tens;
  logic [3:0] hours_ones;
  logic [3:0] minutes_tens;
  logic [3:0] minutes_ones;

  // Detect a press: input high now, low on the previous cycle
  always_comb begin
    minutes_step = i_Minutes_Inc & ~minutes_inc_prev;
    hours_step   = i_Hours_Inc   & ~hours_inc_prev;
  end

  // Edge-detect registers; cleared by reset so a press right after reset counts
  always_ff @(posedge i_Clk_5MHz) begin
    if (i_Reset) begin
      minutes_inc_prev <= 1'b0;
      hours_inc_prev   <= 1'b0;
    end else begin
      minutes_inc_prev <= i_Minutes_Inc;
      hours_inc_prev   <= i_Hours_Inc;
    end
  end

  // Minutes counter: 59 wraps to 0 without carrying into hours
  always_ff @(posedge i_Clk_5MHz) begin
    if (i_Reset) begin
      minutes <= 6'(START_MINUTES);
    end else if (minutes_step) begin
      if (minutes == 6'd59) begin
        minutes <= 6'd0;
      end else begin
        minutes <= minutes + 6'd1;
      end
    end
  end

  // Hours counter: 23 wraps to 0
  always_ff @(posedge i_Clk_5MHz) begin
    if (i_Reset) begin
      hours <= 5'(START_HOURS);
    end else if (hours_step) begin
      if (hours == 5'd23) begin
        hours <= 5'd0;
      end else begin
        hours <= hours + 5'd1;
      end
    end
  end

  // 24-hour to 12-hour conversion: 0 shows as 12, 13-23 drop by 12.
  // For 13-23 the low nibble minus 12 (mod 16) gives the right result.
  always_comb begin
    hours_12 = hours[3:0];
    if (hours == 5'd0) begin
      hours_12 = 4'd12;
    end else if (hours > 5'd12) begin
      hours_12 = hours[3:0] - 4'd12;
    end
  end

  // Hours BCD: 12-hour value is 1-12, so the tens digit is 0 or 1 (never blanked)
  always_comb begin
    hours_tens = 4'd0;
    hours_ones = hours_12;
    if (hours_12 >= 4'd10) begin
      hours_tens = 4'd1;
      hours_ones = hours_12 - 4'd10;
    end
  end

  // Minutes BCD: tens by range compare, ones by subtracting the tens weight
  always_comb begin
    minutes_tens = 4'd0;
    minutes_ones = 4'(minutes);
    if (minutes >= 6'd50) begin
      minutes_tens = 4'd5;
      minutes_ones = 4'(minutes - 6'd50);
    end else if (minutes >= 6'd40) begin
      minutes_tens = 4'd4;
      minutes_ones = 4'(minutes - 6'd40);
    end else if (minutes >= 6'd30) begin
      minutes_tens = 4'd3;
      minutes_ones = 4'(minutes - 6'd30);
    end else if (minutes >= 6'd20) begin
      minutes_tens = 4'd2;
      minutes_ones = 4'(minutes - 6'd20);
    end else if (minutes >= 6'd10) begin
      minutes_tens = 4'd1;
      minutes_ones = 4'(minutes - 6'd10);
    end
  end

  // Output assembly
  always_comb begin
    o_Alarm_Time = {hours_tens, hours_ones, minutes_tens, minutes_ones};
    o_PM         = (hours >= 5'd12);
  end

endmodule

// File: tb/tb_alarm_time.sv
// tb_alarm_time: directed vectors for alarm_time started at 23:00.
// The driver applies one vector per clock and queues the expected display
// word for the cycle after that edge; the monitor pops and compares it.
module tb_alarm_time;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        min_inc;
  logic        hr_inc;
  logic [15:0] alarm_time;
  logic        pm;

  always #100 clk = ~clk;

  alarm_time #(
    .START_MINUTES(0),
    .START_HOURS  (23)
  ) dut (
    .i_Clk_5MHz   (clk),
    .i_Reset      (rst),
    .i_Minutes_Inc(min_inc),
    .i_Hours_Inc  (hr_inc),
    .o_Alarm_Time (alarm_time),
    .o_PM         (pm)
  );

  // ---------------- scoreboard ----------------
  // entry = {check, pm, alarm_time}
  logic [17:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  // Monitor: one entry per applied vector, compared just after the edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [17:0] e;
      e = exp_q.pop_front();
      if (e[17]) begin
        n_vec++;
        if (alarm_time !== e[15:0] || pm !== e[16]) begin
          n_err++;
          $display("FAIL vec%0d: time=%h pm=%b, required time=%h pm=%b",
                   n_vec, alarm_time, pm, e[15:0], e[16]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic mi, input logic hi,
                       input logic chk, input logic [15:0] t, input logic p);
    @(negedge clk);
    rst     = r;
    min_inc = mi;
    hr_inc  = hi;
    exp_q.push_back({chk, p, t});
  endtask

  // n presses (high cycle then low cycle); only the final press is checked
  task automatic press_min(input int n, input logic [15:0] t, input logic p);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1, 1'b0, (i == n - 1), t, p);
      drive(1'b0, 1'b0, 1'b0, 1'b0, t, p);
    end
  endtask

  task automatic press_hr(input int n, input logic [15:0] t, input logic p);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 1'b1, (i == n - 1), t, p);
      drive(1'b0, 1'b0, 1'b0, 1'b0, t, p);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst     = 1'b1;
    min_inc = 1'b0;
    hr_inc  = 1'b0;

    // reset state 23:00 -> 11:00 PM
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h1100, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h1100, 1'b1);

    // hours 23 -> 0 (12 AM) -> 1 (01 AM)
    drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h1200, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h1200, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0100, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0);

    // minutes 0 -> 9 -> 10 -> 59 -> wrap to 0, hours untouched
    press_min(9,  16'h0109, 1'b0);
    press_min(1,  16'h0110, 1'b0);
    press_min(49, 16'h0159, 1'b0);
    press_min(1,  16'h0100, 1'b0);

    // button held for 10 cycles: exactly one step
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0101, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0101, 1'b0);

    // three separate one-cycle pulses: +3
    press_min(1, 16'h0102, 1'b0);
    press_min(1, 16'h0103, 1'b0);
    press_min(1, 16'h0104, 1'b0);

    // walk to 11:59 AM
    press_hr(9,   16'h1004, 1'b0);
    press_hr(1,   16'h1104, 1'b0);
    press_min(55, 16'h1159, 1'b0);

    // simultaneous edges: 11:59 -> 12:00 PM
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h1200, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h1200, 1'b1);

    // hours 12 -> 13 shows 01 PM
    press_hr(1, 16'h0100, 1'b1);

    // rising edges coincident with reset: reset wins
    drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h1100, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h1100, 1'b1);

    // reset asserted mid-press: reload, press ignored
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h1101, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h1100, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h1100, 1'b1);

    // let the monitor drain the queue, bounded
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
